// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and a
// helper that derives the pointer width from the storage depth.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_DEPTH      = 16;

   // Pointer width for a power-of-two depth (DEPTH >= 2).
   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array, one synchronous write
// port and one asynchronous read address. Contents are not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_W     = fifo_addr_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Store write data on the rising edge when the write is accepted.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO top: pointers, occupancy counter, full/empty flags and
// the registered read-data output. Storage lives in fifo_mem.
module fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int ADDR_W = fifo_addr_w(DEPTH);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W:0]       count;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   // Flags come straight from the registered occupancy, so they describe
   // the state left by the most recent edge. A write into a full FIFO and
   // a read from an empty one are simply not accepted; this also gives the
   // "write only when empty" and "read only when full" simultaneous cases.
   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (din),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // Write pointer advances on each accepted write, wrapping naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (wr_acc) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer advances on each accepted read, wrapping naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
      end else if (rd_acc) begin
         rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered read data: loads only on an accepted read, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
      end else if (rd_acc) begin
         dout <= rd_data;
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed sequence plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_fifo;

   localparam int DW = 8;
   localparam int DEPTH = 16;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;

   int checks;
   int failures;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] model_dout;

   fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".dout"},  32'(dout),  32'(model_dout));
      check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
      check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
   endtask

   // One clock cycle: drive at the falling edge, update the model at the
   // rising edge from the occupancy seen before it, then compare.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
      bit wacc;
      bit racc;
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      wacc = w && (model_q.size() < DEPTH);
      racc = r && (model_q.size() > 0);
      if (racc) model_dout = model_q.pop_front();
      if (wacc) model_q.push_back(d);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_q.delete();
      model_dout = '0;
      #1;
      check_outputs("reset_during");
      #19;
      check_outputs("reset_hold");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_outputs("reset_after");
   endtask

   initial begin
      logic [DW-1:0] rnd;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      din      = '0;
      model_dout = '0;
      #2;
      do_reset();

      // Fill with FF..F0, then attempt 0x11 into the full FIFO.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'hFF - 8'(i), "fill");
      check("full_after_16", 32'(full), 32'd1);
      step(1'b1, 1'b0, 8'h11, "drop_when_full");
      check("still_full", 32'(full), 32'd1);

      // Drain, expecting FF..F0 in order.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00, "drain");
         check("drain_data", 32'(dout), 32'(8'hFF - 8'(i)));
      end
      check("empty_after_16", 32'(empty), 32'd1);

      // Reads while empty: dout holds F0.
      step(1'b0, 1'b1, 8'h00, "rd_empty0");
      step(1'b0, 1'b1, 8'h00, "rd_empty1");
      check("hold_f0", 32'(dout), 32'h0000_00F0);

      // 10 in, 10 out, then 12 across the pointer wrap.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), "w10");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "r10");
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom), "w12_wrap");
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, "r12_wrap");
      check("empty_after_wrap", 32'(empty), 32'd1);

      // Simultaneous at occupancy 0: write only.
      step(1'b1, 1'b1, 8'hA0, "sim_occ0");
      check("sim_occ0_not_empty", 32'(empty), 32'd0);
      // Bring to 5, simultaneous: both accepted.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hB0 + 8'(i), "to5");
      step(1'b1, 1'b1, 8'hC5, "sim_occ5");
      check("sim_occ5_first_out", 32'(dout), 32'h0000_00A0);
      // Bring to 16, simultaneous: read only.
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'($urandom), "to16");
      check("full_at_16", 32'(full), 32'd1);
      step(1'b1, 1'b1, 8'h5A, "sim_occ16");
      check("sim_occ16_not_full", 32'(full), 32'd0);
      // Down to 7, then reset mid-operation.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "to7");
      check("occ7", 32'(model_q.size()), 32'd7);
      do_reset();

      // Random traffic against the model, exercising wraps and both flags.
      for (int i = 0; i < 400; i++) begin
         rnd = 8'($urandom);
         step(1'(($urandom % 100) < 55), 1'(($urandom % 100) < 50), rnd, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of din and dout.
REQ-002 Parameter DEPTH, default 16: number of storage entries; must be a power of two, minimum 2.
REQ-003 Derived constant ADDR_W = log2(DEPTH), default 4: pointer width; the occupancy counter is ADDR_W+1 bits wide.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 Port wr_en, input, 1 bit: write request, sampled on the rising clk edge.
REQ-007 Port rd_en, input, 1 bit: read request, sampled on the rising clk edge.
REQ-008 Port din, input, DATA_WIDTH bits: write data, sampled with wr_en.
REQ-009 Port dout, output, DATA_WIDTH bits: registered read data.
REQ-010 Port full, output, 1 bit: high when occupancy equals DEPTH.
REQ-011 Port empty, output, 1 bit: high when occupancy equals 0.
REQ-012 Port order shall be exactly: clk, reset, wr_en, rd_en, din, dout, full, empty.

Function
REQ-013 Storage shall be first-in first-out; data shall be read in exactly the order it was accepted.
REQ-014 A write shall be accepted on a rising edge iff wr_en=1 and full=0 before that edge.
REQ-015 On an accepted write: din is stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-016 A write with full=1 shall be silently dropped; no state shall change because of it.
REQ-017 A read shall be accepted on a rising edge iff rd_en=1 and empty=0 before that edge.
REQ-018 On an accepted read: dout loads mem[rd_ptr] at that edge (one-cycle latency); rd_ptr increments modulo DEPTH.
REQ-019 A read with empty=1 shall be ignored; dout shall hold its last value.
REQ-020 dout shall change only on an accepted read or on reset.
REQ-021 Occupancy shall change as follows: +1 for write only, -1 for read only, unchanged when both are accepted in the same cycle.
REQ-022 Simultaneous wr_en and rd_en when empty: only the write is accepted (no read-through); empty deasserts after the edge.
REQ-023 Simultaneous wr_en and rd_en when full: only the read is accepted; the write is dropped; full deasserts after the edge.
REQ-024 Simultaneous wr_en and rd_en when partially filled: both are accepted; occupancy, full and empty are unchanged.
REQ-025 full and empty shall be decoded from the registered occupancy counter and shall reflect the state after the most recent edge.
REQ-026 Pointer wrap-around from DEPTH-1 to 0 shall be seamless, with no loss or duplication of data.
REQ-027 Writes and reads may each be issued every cycle at full throughput.

Reset
REQ-028 While reset=1, asynchronously: wr_ptr=0, rd_ptr=0, occupancy=0, dout=0, empty=1, full=0.
REQ-029 Reset asserted mid-operation shall discard all stored data; memory contents need not be cleared.
REQ-030 After reset deasserts, the first rising edge shall be a normal operating edge.

Structure
REQ-031 DATA_WIDTH and DEPTH defaults shall be defined as constants in shared package fifo_pkg.
REQ-032 Storage shall be a sub-module fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one asynchronous read address, and no reset.
REQ-033 Pointers, the occupancy counter, the flags and the dout register shall reside in fifo.

Verification
REQ-034 Reset pulse of 20 ns -> empty=1, full=0, dout=0x00 during and after reset.
REQ-035 Write FF,FE,...,F0 on 16 consecutive cycles, then 0x11 -> full=1 after the 16th write; 0x11 is dropped; occupancy stays 16.
REQ-036 Read 16 consecutive cycles -> dout = FF,FE,...,F0 one cycle after each request; empty=1 after the 16th read.
REQ-037 Hold rd_en=1 for 2 extra cycles while empty -> dout holds F0; empty stays 1; pointers do not move.
REQ-038 Write 10, read 10, then write 12 values (crossing the pointer wrap) and read them back -> order preserved; flags correct at 0 and 16 entries.
REQ-039 Simultaneous wr_en and rd_en at occupancy 0, 5 and 16 -> behaviour per REQ-022 to REQ-024; assert reset at occupancy 7 -> empty=1 and dout=0 immediately.
